// File: rtl/signbit_32_pkg.sv
// signbit_32_pkg: widths and types shared by the pipelined unsigned multiplier.
package signbit_32_pkg;
    localparam int W   = 32;
    localparam int HW  = W / 2;
    localparam int PW  = 2 * W;
    localparam int LAT = 3;
    typedef logic [W-1:0]  operand_t;
    typedef logic [HW-1:0] half_t;
    typedef logic [W-1:0]  pp_t;
    typedef logic [PW-1:0] prod_t;
endpackage

// File: rtl/signbit_32_mul_half.sv
// mul_half: combinational HW x HW -> W unsigned partial-product multiplier.
module mul_half
    import signbit_32_pkg::*;
(
    input  logic [HW-1:0] i_a,
    input  logic [HW-1:0] i_b,
    output logic [W-1:0]  o_p
);
    assign o_p = pp_t'(i_a) * pp_t'(i_b);
endmodule

// File: rtl/signbit_32.sv
// signbit_32: 3-stage pipelined W x W unsigned multiplier with exact 2W-bit product.
module signbit_32
    import signbit_32_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          out_valid,
    output logic [PW-1:0] p
);
    operand_t r_a, r_b;
    logic     r_v1, r_v2, r_v3;
    pp_t      r_ll, r_lh, r_hl, r_hh;
    prod_t    r_p;
    pp_t      w_ll, w_lh, w_hl, w_hh;
    logic [W:0] w_mid;
    prod_t    w_sum;

    mul_half u_ll (.i_a(r_a[HW-1:0]), .i_b(r_b[HW-1:0]), .o_p(w_ll));
    mul_half u_lh (.i_a(r_a[HW-1:0]), .i_b(r_b[W-1:HW]), .o_p(w_lh));
    mul_half u_hl (.i_a(r_a[W-1:HW]), .i_b(r_b[HW-1:0]), .o_p(w_hl));
    mul_half u_hh (.i_a(r_a[W-1:HW]), .i_b(r_b[W-1:HW]), .o_p(w_hh));

    // The cross-term sum needs W+1 bits; dropping its carry loses 2^(W+HW).
    assign w_mid = {1'b0, r_lh} + {1'b0, r_hl};
    assign w_sum = {{W{1'b0}}, r_ll}
                 + {{(W-HW-1){1'b0}}, w_mid, {HW{1'b0}}}
                 + {r_hh, {W{1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a  <= '0;
            r_b  <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_a <= a;
                r_b <= b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ll <= '0;
            r_lh <= '0;
            r_hl <= '0;
            r_hh <= '0;
            r_v2 <= 1'b0;
        end else begin
            r_ll <= w_ll;
            r_lh <= w_lh;
            r_hl <= w_hl;
            r_hh <= w_hh;
            r_v2 <= r_v1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p  <= '0;
            r_v3 <= 1'b0;
        end else begin
            r_v3 <= r_v2;
            if (r_v2) r_p <= w_sum;
        end
    end

    assign out_valid = r_v3;
    assign p         = r_p;
endmodule

// File: tb/tb_signbit_32.sv
// tb_signbit_32: scoreboard bench for the pipelined unsigned multiplier.
module tb_signbit_32;
    import signbit_32_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    logic     in_valid = 1'b0;
    operand_t a = '0;
    operand_t b = '0;
    logic     out_valid;
    prod_t    p;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        prod_t prod;
        int    due;
    } exp_t;
    exp_t sb[$];

    signbit_32 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a), .b(b), .out_valid(out_valid), .p(p)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input prod_t obs, input prod_t exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Each issued pair must emerge exactly LAT edges after its sampling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) check("stale_valid", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("latency", prod_t'(cyc), prod_t'(e.due));
                    check("product", p, e.prod);
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                check("missing_valid", 0, 1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic drive(input operand_t x, input operand_t y);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = x;
        b = y;
        e.prod = prod_t'(x) * prod_t'(y);
        e.due  = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    initial begin
        #12;
        check("reset_valid", prod_t'(out_valid), 0);
        check("reset_p", p, 0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(32'd12, 32'd4);
        repeat (5) idle();
        @(negedge clk);
        check("hold_valid", prod_t'(out_valid), 0);
        check("hold_p", p, 64'd48);

        drive(32'd12, 32'd4);
        drive(32'd3, 32'd4);
        drive(32'd0, 32'hDEADBEEF);
        drive(32'd1, 32'hFFFFFFFF);
        drive(32'hFFFFFFFF, 32'hFFFFFFFF);
        drive(32'h0001_0000, 32'h0001_0000);
        drive(32'h0000_FFFF, 32'hFFFF_0000);
        drive(32'hFFFF_0001, 32'h0001_FFFF);
        repeat (5) idle();
        @(negedge clk);
        check("max_hold", p, 64'hFFFF_0001 * 64'h0001_FFFF);

        drive(32'd5, 32'd7);
        idle();
        drive(32'd9, 32'd9);
        idle();
        idle();
        @(negedge clk);
        check("gap_valid", prod_t'(out_valid), 0);
        check("gap_hold_p", p, 64'd35);
        repeat (3) idle();
        @(negedge clk);
        check("gap_final_p", p, 64'd81);

        drive(32'd7, 32'd8);
        drive(32'd6, 32'd6);
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        check("async_valid", prod_t'(out_valid), 0);
        check("async_p", p, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) idle();
        @(negedge clk);
        check("post_reset_p", p, 0);

        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(9) < 7) drive($urandom, $urandom);
            else idle();
        end
        drive(32'hFFFFFFFF, 32'd1);
        repeat (6) idle();
        @(negedge clk);
        check("drained", prod_t'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
